// File: rtl/eight_data_decompress_unit.sv
// Purpose: restores eight 32-bit words from one tagged/packed compressed beat and undoes the 16-bit cross-beat skew.
// Latency: bypass 3 enabled edges; compressed beat 3 edges after its successor is accepted; tlast flush 4 edges.
// Backpressure: ready_out drops for one enabled cycle after a compressed tlast beat to open the flush slot.
module eight_data_decompress_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 2,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wrtEn,
    input  logic [3:0]              flags_in,
    input  logic [8*DATA_WIDTH-1:0] dataIn,
    input  logic [8*TAG_WIDTH-1:0]  tagIn,
    input  logic [LEN_WIDTH-1:0]    lenIn,
    output logic                    ready_out,
    output logic [8*DATA_WIDTH-1:0] dataOut,
    output logic [3:0]              flags_out,
    output logic                    err
);

    localparam int NW   = 8;
    localparam int BW   = NW * DATA_WIDTH;
    localparam int HALF = 16;

    typedef enum logic [1:0] {IDLE, PENDING, FLUSH} state_t;

    // flags encoding: [3] valid, [2] tlast, [1] compression, [0] header
    function automatic logic isBypass(input logic [3:0] f);
        return !f[1] || f[0];
    endfunction

    function automatic logic [LEN_WIDTH-1:0] tagBytes(input logic [TAG_WIDTH-1:0] t);
        case (t)
            2'b00:   return LEN_WIDTH'(0);
            2'b01:   return LEN_WIDTH'(1);
            2'b10:   return LEN_WIDTH'(2);
            default: return LEN_WIDTH'(DATA_WIDTH / 8);
        endcase
    endfunction

    logic accept;
    assign accept = wrtEn && flags_in[3] && ready_out;

    // stage A registers
    logic                 aVld;
    logic [3:0]           aFlags;
    logic [BW-1:0]        aData;
    logic [8*TAG_WIDTH-1:0] aTag;
    logic [LEN_WIDTH-1:0] aLen;

    // stage B registers
    logic                 bVld;
    logic [3:0]           bFlags;
    logic [BW-1:0]        bData;
    logic                 bLenErr;

    // stage C / FSM state
    state_t               state;
    logic [BW-1:0]        pend;
    logic [3:0]           pendFlags;

    // decode helpers
    logic [BW-1:0]         decoded;
    logic [LEN_WIDTH-1:0]  run;
    logic [BW-1:0]         shifted;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] word;
    logic                  lenErr;

    // Walk the tags to find each word's byte offset and expand it to a full word.
    always_comb begin
        decoded = '0;
        run     = '0;
        shifted = '0;
        tag     = '0;
        word    = '0;
        for (int i = 0; i < NW; i++) begin
            tag     = aTag[TAG_WIDTH*i +: TAG_WIDTH];
            shifted = aData >> (8 * run);
            case (tag)
                2'b00:   word = '0;
                2'b01:   word = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
                2'b10:   word = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
                default: word = shifted[DATA_WIDTH-1:0];
            endcase
            decoded[DATA_WIDTH*i +: DATA_WIDTH] = word;
            run = run + tagBytes(tag);
        end
        // two trailing bytes carry the tags themselves
        lenErr = aVld && !isBypass(aFlags) && ((run + LEN_WIDTH'(2)) != aLen);
    end

    // Stages A and B: register the accepted beat, then register its decoded (or bypassed) payload.
    always_ff @(posedge clk) begin
        if (reset) begin
            aVld    <= 1'b0;
            aFlags  <= '0;
            aData   <= '0;
            aTag    <= '0;
            aLen    <= '0;
            bVld    <= 1'b0;
            bFlags  <= '0;
            bData   <= '0;
            bLenErr <= 1'b0;
        end else if (wrtEn) begin
            aVld    <= accept;
            aFlags  <= flags_in;
            aData   <= dataIn;
            aTag    <= tagIn;
            aLen    <= lenIn;
            bVld    <= aVld;
            bFlags  <= aFlags;
            bData   <= isBypass(aFlags) ? aData : decoded;
            bLenErr <= lenErr;
        end
    end

    // One-cycle bubble after a compressed tlast so the held tail can be flushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            ready_out <= 1'b1;
        end else if (wrtEn) begin
            ready_out <= !(accept && !isBypass(flags_in) && flags_in[2]);
        end
    end

    // Realign FSM: each output combines the held beat's upper 240 bits with the next beat's low 16 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pend      <= '0;
            pendFlags <= '0;
            dataOut   <= '0;
            flags_out <= '0;
            err       <= 1'b0;
        end else if (wrtEn) begin
            dataOut   <= '0;
            flags_out <= '0;
            err       <= err | bLenErr;
            case (state)
                IDLE: begin
                    if (bVld) begin
                        if (isBypass(bFlags)) begin
                            dataOut   <= bData;
                            flags_out <= bFlags;
                        end else if (bFlags[2]) begin
                            dataOut   <= {{HALF{1'b0}}, bData[BW-1:HALF]};
                            flags_out <= bFlags;
                        end else begin
                            pend      <= bData;
                            pendFlags <= bFlags;
                            state     <= PENDING;
                        end
                    end
                end
                PENDING: begin
                    if (bVld) begin
                        if (isBypass(bFlags)) begin
                            // stream broken mid-packet: drop the held beat
                            err       <= 1'b1;
                            dataOut   <= bData;
                            flags_out <= bFlags;
                            state     <= IDLE;
                        end else begin
                            dataOut   <= {bData[HALF-1:0], pend[BW-1:HALF]};
                            flags_out <= pendFlags;
                            pend      <= bData;
                            pendFlags <= bFlags;
                            state     <= bFlags[2] ? FLUSH : PENDING;
                        end
                    end
                end
                FLUSH: begin
                    // stage B is empty here thanks to the ready_out bubble
                    dataOut   <= {{HALF{1'b0}}, pend[BW-1:HALF]};
                    flags_out <= pendFlags;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eight_data_decompress_unit.sv
module tb_eight_data_decompress_unit;

    logic         clk = 1'b0;
    logic         reset;
    logic         wrtEn;
    logic [3:0]   flags_in;
    logic [255:0] dataIn;
    logic [15:0]  tagIn;
    logic [7:0]   lenIn;
    logic         ready_out;
    logic [255:0] dataOut;
    logic [3:0]   flags_out;
    logic         err;

    int checks = 0;
    int errors = 0;

    eight_data_decompress_unit dut (
        .clk       (clk),
        .reset     (reset),
        .wrtEn     (wrtEn),
        .flags_in  (flags_in),
        .dataIn    (dataIn),
        .tagIn     (tagIn),
        .lenIn     (lenIn),
        .ready_out (ready_out),
        .dataOut   (dataOut),
        .flags_out (flags_out),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [3:0] f, input logic [255:0] d, input logic [15:0] t, input logic [7:0] l);
        flags_in = f;
        dataIn   = d;
        tagIn    = t;
        lenIn    = l;
    endtask

    task automatic idle();
        drive(4'b0000, '0, '0, '0);
    endtask

    logic [255:0] inc;
    logic [255:0] x;
    logic [255:0] x2exp;
    logic [255:0] d0;
    logic [255:0] d1;
    logic [255:0] pmix;
    logic [255:0] dmix;

    initial begin
        for (int i = 0; i < 8; i++) begin
            inc[32*i +: 32] = 32'h1111_0000 + 32'(i);
            x[32*i +: 32]   = 32'hA5A5_0000 + 32'(i);
        end
        d0 = x << 16;
        d1 = (x << 16) | (x >> 240);
        x2exp = x;
        x2exp[255:240] = 16'h0;
        pmix = {144'h0, 32'hDEADBEEF, 16'h8001, 8'h05, 32'h12345678, 16'h7FFF, 8'h80};
        dmix = {32'hDEADBEEF, 32'hFFFF8001, 32'h00000005, 32'h00000000,
                32'h12345678, 32'h00007FFF, 32'hFFFFFF80, 32'h00000000};

        // reset state
        reset = 1'b1;
        wrtEn = 1'b1;
        idle();
        tick();
        tick();
        check("rst_data", dataOut, '0);
        check("rst_flags", flags_out, 4'b0000);
        check("rst_err", err, 1'b0);
        check("rst_ready", ready_out, 1'b1);
        reset = 1'b0;

        // header beat passes through after three edges
        drive(4'b1001, inc, 16'hFFFF, 8'd0);
        tick();
        check("hdr_ready", ready_out, 1'b1);
        idle();
        tick();
        check("hdr_early", flags_out, 4'b0000);
        tick();
        check("hdr_data", dataOut, inc);
        check("hdr_flags", flags_out, 4'b1001);
        tick();
        check("hdr_after", flags_out, 4'b0000);

        // three raw compressed beats, last one tlast
        drive(4'b1010, d0, 16'hFFFF, 8'd34);
        tick();
        drive(4'b1010, d1, 16'hFFFF, 8'd34);
        tick();
        drive(4'b1110, d1, 16'hFFFF, 8'd34);
        tick();
        check("c3_ready_low", ready_out, 1'b0);
        check("c3_hold", flags_out, 4'b0000);
        idle();
        tick();
        check("c3_ready_back", ready_out, 1'b1);
        check("c3_x0_data", dataOut, x);
        check("c3_x0_flags", flags_out, 4'b1010);
        tick();
        check("c3_x1_data", dataOut, x);
        check("c3_x1_flags", flags_out, 4'b1010);
        tick();
        check("c3_x2_data", dataOut, x2exp);
        check("c3_x2_flags", flags_out, 4'b1110);
        check("c3_err", err, 1'b0);
        tick();
        check("c3_after", flags_out, 4'b0000);

        // mixed tags, single tlast beat with correct length
        drive(4'b1110, pmix, 16'hE4E4, 8'd16);
        tick();
        check("mix_ready_low", ready_out, 1'b0);
        idle();
        tick();
        check("mix_ready_back", ready_out, 1'b1);
        tick();
        check("mix_data", dataOut, dmix >> 16);
        check("mix_flags", flags_out, 4'b1110);
        check("mix_err", err, 1'b0);
        tick();
        check("mix_after", flags_out, 4'b0000);

        // compressed beat interrupted by a bypass beat
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst2_err", err, 1'b0);
        drive(4'b1010, d0, 16'hFFFF, 8'd34);
        tick();
        drive(4'b1000, inc, 16'h0000, 8'd32);
        tick();
        idle();
        tick();
        check("brk_hold", flags_out, 4'b0000);
        tick();
        check("brk_data", dataOut, inc);
        check("brk_flags", flags_out, 4'b1000);
        check("brk_err", err, 1'b1);
        tick();
        check("brk_after", flags_out, 4'b0000);

        // length off by one: err set, data still decoded
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(4'b1110, pmix, 16'hE4E4, 8'd17);
        tick();
        idle();
        tick();
        tick();
        check("len_data", dataOut, dmix >> 16);
        check("len_err", err, 1'b1);
        drive(4'b1001, inc, 16'h0000, 8'd32);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("len_err_sticky", err, 1'b1);

        // freeze mid-stream, then reset mid-stream
        drive(4'b1010, d0, 16'hFFFF, 8'd34);
        tick();
        drive(4'b1010, d1, 16'hFFFF, 8'd34);
        tick();
        idle();
        tick();
        tick();
        check("frz_pre_data", dataOut, x);
        check("frz_pre_flags", flags_out, 4'b1010);
        wrtEn = 1'b0;
        drive(4'b1001, inc, 16'h0000, 8'd32);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("frz_data", dataOut, x);
            check("frz_flags", flags_out, 4'b1010);
            check("frz_ready", ready_out, 1'b1);
            check("frz_err", err, 1'b1);
        end
        wrtEn = 1'b1;
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_data", dataOut, '0);
        check("mrst_flags", flags_out, 4'b0000);
        check("mrst_ready", ready_out, 1'b1);
        check("mrst_err", err, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mrst_drained", flags_out, 4'b0000);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
